// File: rtl/exu_lsuagu_split_pkg.sv
// Shared encodings for the LSU address-generation unit: FSM states, access size codes
// and the default boundary-split policy.
package exu_lsuagu_split_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD1 = 3'd1,
    ST_RSP1 = 3'd2,
    ST_CMD2 = 3'd3,
    ST_RSP2 = 3'd4,
    ST_WBCK = 3'd5
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam bit SPLIT_EN_DEFAULT = 1'b1;

endpackage

// File: rtl/exu_lsuagu_algn.sv
// Combinational lane alignment: store-data rotation, two-beat byte mask, and load
// extraction with sign/zero extension.
module exu_lsuagu_algn
  import exu_lsuagu_split_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int B    = XLEN / 8,
  localparam int LB   = $clog2(B)
) (
  input  logic [LB-1:0]   i_off,
  input  logic [1:0]      i_size,
  input  logic            i_usign,
  input  logic            i_cross,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_rdata1,
  input  logic [XLEN-1:0] i_rdata2,
  output logic [XLEN-1:0] o_wdata,
  output logic [2*B-1:0]  o_mask,
  output logic [XLEN-1:0] o_ldata
);

  logic [LB+2:0]     w_sh;
  logic [2*XLEN-1:0] w_cat;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_keep;
  logic              w_sign;
  logic [2*B-1:0]    w_base;

  assign w_sh = {i_off, 3'b000};

  // Upper half of the doubled word shifted left is a left rotation.
  assign o_wdata = XLEN'(({i_rs2, i_rs2} << w_sh) >> XLEN);

  always_comb begin
    w_base = '0;
    case (i_size)
      SZ_B: w_base = (2*B)'(8'h01);
      SZ_H: w_base = (2*B)'(8'h03);
      SZ_W: w_base = (2*B)'(8'h0F);
      SZ_D: w_base = (2*B)'(8'hFF);
    endcase
  end

  assign o_mask = w_base << i_off;

  assign w_cat = i_cross ? {i_rdata2, i_rdata1} : {{XLEN{1'b0}}, i_rdata1};
  assign w_raw = XLEN'(w_cat >> w_sh);

  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (i_size)
      SZ_B: begin w_keep = XLEN'(8'hFF);         w_sign = w_raw[7];  end
      SZ_H: begin w_keep = XLEN'(16'hFFFF);      w_sign = w_raw[15]; end
      SZ_W: begin w_keep = XLEN'(32'hFFFF_FFFF); w_sign = w_raw[31]; end
      SZ_D: begin end
    endcase
  end

  assign o_ldata = (w_raw & w_keep) | ({XLEN{w_sign & ~i_usign}} & ~w_keep);

endmodule

// File: rtl/exu_lsuagu_split.sv
// LSU address-generation unit: EA adder, one- or two-beat ICB command/response FSM,
// and aligned load write-back with misaligned / bus-error commit flags.
module exu_lsuagu_split
  import exu_lsuagu_split_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter bit SPLIT_EN  = SPLIT_EN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 agu_i_valid,
  output logic                 agu_i_ready,
  input  logic [XLEN-1:0]      agu_i_rs1,
  input  logic [XLEN-1:0]      agu_i_rs2,
  input  logic [XLEN-1:0]      agu_i_imm,
  input  logic                 agu_i_load,
  input  logic                 agu_i_store,
  input  logic [1:0]           agu_i_size,
  input  logic                 agu_i_usign,
  output logic                 agu_o_valid,
  input  logic                 agu_o_ready,
  output logic [XLEN-1:0]      agu_o_wbck_wdat,
  output logic                 agu_o_cmt_ld,
  output logic                 agu_o_cmt_stamo,
  output logic                 agu_o_cmt_misalgn,
  output logic                 agu_o_cmt_buserr,
  output logic [ADDR_SIZE-1:0] agu_o_cmt_badaddr,
  output logic                 agu_icb_cmd_valid,
  input  logic                 agu_icb_cmd_ready,
  output logic [ADDR_SIZE-1:0] agu_icb_cmd_addr,
  output logic                 agu_icb_cmd_read,
  output logic [XLEN-1:0]      agu_icb_cmd_wdata,
  output logic [XLEN/8-1:0]    agu_icb_cmd_wmask,
  input  logic                 agu_icb_rsp_valid,
  output logic                 agu_icb_rsp_ready,
  input  logic [XLEN-1:0]      agu_icb_rsp_rdata,
  input  logic                 agu_icb_rsp_err
);

  localparam int B  = XLEN / 8;
  localparam int LB = $clog2(B);

  state_e               r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0] r_ea, r_badaddr;
  logic [XLEN-1:0]      r_rs2, r_rdata1, r_rdata2;
  logic [1:0]           r_size;
  logic                 r_usign, r_load, r_store, r_cross, r_misalgn, r_buserr;

  logic [ADDR_SIZE-1:0] w_ea_in, w_a0, w_a1;
  logic [LB+3:0]        w_end_in;
  logic                 w_cross_in, w_misalgn_in, w_acc, w_cmd, w_wbck, w_fault;
  logic [XLEN-1:0]      w_wdata, w_ldata;
  logic [2*B-1:0]       w_mask;

  assign w_ea_in      = ADDR_SIZE'(agu_i_rs1 + agu_i_imm);
  assign w_end_in     = (LB+4)'(w_ea_in[LB-1:0]) + ((LB+4)'(1) << agu_i_size);
  assign w_cross_in   = w_end_in > (LB+4)'(B);
  // Doubleword on a 32-bit datapath can never be served, so it is reported as misaligned.
  assign w_misalgn_in = ((agu_i_size == SZ_D) && (XLEN == 32)) || (w_cross_in && !SPLIT_EN);
  assign w_acc        = agu_i_valid && agu_i_ready;

  assign w_a0 = r_ea & ~ADDR_SIZE'(B - 1);
  assign w_a1 = w_a0 + ADDR_SIZE'(B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (agu_i_valid) w_state_nxt = w_misalgn_in ? ST_WBCK : ST_CMD1;
      ST_CMD1: if (agu_icb_cmd_ready) w_state_nxt = ST_RSP1;
      ST_RSP1: if (agu_icb_rsp_valid)
                 w_state_nxt = (agu_icb_rsp_err || !r_cross) ? ST_WBCK : ST_CMD2;
      ST_CMD2: if (agu_icb_cmd_ready) w_state_nxt = ST_RSP2;
      ST_RSP2: if (agu_icb_rsp_valid) w_state_nxt = ST_WBCK;
      ST_WBCK: if (agu_o_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ea      <= '0;
      r_badaddr <= '0;
      r_rs2     <= '0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_size    <= '0;
      r_usign   <= 1'b0;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_cross   <= 1'b0;
      r_misalgn <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_ea      <= w_ea_in;
        r_badaddr <= w_ea_in;
        r_rs2     <= agu_i_rs2;
        r_size    <= agu_i_size;
        r_usign   <= agu_i_usign;
        r_load    <= agu_i_load;
        r_store   <= agu_i_store;
        r_cross   <= w_cross_in;
        r_misalgn <= w_misalgn_in;
        r_buserr  <= 1'b0;
      end
      if (r_state == ST_RSP1 && agu_icb_rsp_valid) begin
        r_rdata1 <= agu_icb_rsp_rdata;
        if (agu_icb_rsp_err) r_buserr <= 1'b1;
      end
      if (r_state == ST_RSP2 && agu_icb_rsp_valid) begin
        r_rdata2 <= agu_icb_rsp_rdata;
        if (agu_icb_rsp_err) begin
          r_buserr  <= 1'b1;
          r_badaddr <= w_a1;
        end
      end
    end
  end

  exu_lsuagu_algn #(.XLEN(XLEN)) u_algn (
    .i_off    (r_ea[LB-1:0]),
    .i_size   (r_size),
    .i_usign  (r_usign),
    .i_cross  (r_cross),
    .i_rs2    (r_rs2),
    .i_rdata1 (r_rdata1),
    .i_rdata2 (r_rdata2),
    .o_wdata  (w_wdata),
    .o_mask   (w_mask),
    .o_ldata  (w_ldata)
  );

  assign w_cmd   = (r_state == ST_CMD1) || (r_state == ST_CMD2);
  assign w_wbck  = (r_state == ST_WBCK);
  assign w_fault = r_misalgn || r_buserr;

  assign agu_i_ready       = (r_state == ST_IDLE);
  assign agu_icb_cmd_valid = w_cmd;
  assign agu_icb_cmd_addr  = !w_cmd ? '0 : (r_state == ST_CMD2) ? w_a1 : w_a0;
  assign agu_icb_cmd_read  = w_cmd && r_load;
  assign agu_icb_cmd_wdata = w_cmd ? w_wdata : '0;
  assign agu_icb_cmd_wmask = (r_state == ST_CMD1) ? w_mask[B-1:0] :
                             (r_state == ST_CMD2) ? w_mask[2*B-1:B] : '0;
  assign agu_icb_rsp_ready = (r_state == ST_RSP1) || (r_state == ST_RSP2);

  assign agu_o_valid       = w_wbck;
  assign agu_o_cmt_ld      = w_wbck && r_load;
  assign agu_o_cmt_stamo   = w_wbck && r_store;
  assign agu_o_cmt_misalgn = w_wbck && r_misalgn;
  assign agu_o_cmt_buserr  = w_wbck && r_buserr;
  assign agu_o_cmt_badaddr = (w_wbck && w_fault) ? r_badaddr : '0;
  assign agu_o_wbck_wdat   = (w_wbck && r_load && !w_fault) ? w_ldata : '0;

endmodule
